sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, successor to the fixed 16x8 FIFO: any depth >= 2, any width,
//  occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow
//  errors, simultaneous read+write when full, and an optional first-word-fall-through mode.
//  Sits between producer/consumer blocks sharing one clock as the standard buffering element.
// PARAMETERS
//  DATA_WIDTH  8   width of w_data / r_data in bits (>= 1)
//  DEPTH       16  number of storage words (>= 2; not required to be a power of two)
//  AF_LEVEL    12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    4   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT        0   0: registered read, data 1 cycle after r_en; 1: head word shown on r_data
// PORTS
//  clk           in   1            sole clock; all state updates on rising edge
//  rst_n         in   1            synchronous, active-low reset
//  w_en          in   1            write request
//  w_data        in   DATA_WIDTH   write data
//  r_en          in   1            read request (FWFT=1: pop/acknowledge of head word)
//  r_data        out  DATA_WIDTH   read data
//  r_valid       out  1            r_data holds a valid read word
//  full          out  1            count == DEPTH
//  empty         out  1            count == 0
//  almost_full   out  1            count >= AF_LEVEL
//  almost_empty  out  1            count <= AE_LEVEL
//  count         out  CW           occupancy 0..DEPTH, CW = $clog2(DEPTH+1)
//  overflow      out  1            sticky: write requested while full and not accepted
//  underflow     out  1            sticky: read requested while empty
//  clr_err       in   1            clears overflow/underflow next edge
// BEHAVIOUR
//  - Reset: one clock, single synchronous active-low reset rst_n. rst_n low at a clk edge:
//    wr_ptr=rd_ptr=0, count=0, r_data=0, r_valid=0, overflow=underflow=0. Memory not cleared;
//    contents discarded. Reset mid-operation wins over any w_en/r_en that cycle.
//  - Flags full/empty/almost_*/count are registered-state decodes, valid the cycle after update.
//  - rd_acc = r_en & !empty. wr_acc = w_en & (!full | rd_acc): write while full is accepted
//    only with a same-cycle accepted read.
//  - count_next = count + wr_acc - rd_acc; both accepted -> count unchanged.
//  - Pointers are 0..DEPTH-1 indices; increment wraps DEPTH-1 -> 0 (no MSB trick; count drives
//    flags so non-power-of-two DEPTH works).
//  - FWFT=0: on rd_acc, r_data <= mem[rd_ptr] and r_valid <= 1 next cycle; otherwise r_valid <= 0
//    and r_data holds. Empty + w_en + r_en: write only, underflow set.
//  - FWFT=1: r_data = mem[rd_ptr] whenever !empty (r_data undefined-but-stable value otherwise);
//    r_valid = !empty. Word written at edge N is visible at r_data after edge N when FIFO was
//    empty (latency 1). r_en with !empty pops; next word presented same cycle pop completes.
//  - overflow <= 1 when w_en & full & !rd_acc; underflow <= 1 when r_en & empty.
//    clr_err and a new error event in the same cycle: error stays set (set wins).
//  - Parameter checks: elaboration error if DEPTH<2, AF_LEVEL not in 1..DEPTH, AE_LEVEL>=DEPTH.
// STRUCTURE
//  - Shared package fifo_pkg: function clog2-based width helpers (CW for count, PW for pointer),
//    ptr_inc(ptr, DEPTH) wrap function, FWFT mode constants FIFO_MODE_STD/FIFO_MODE_FWFT.
//  - One sub-module fifo_mem_2p: DATA_WIDTH x DEPTH storage, 1 sync write port, 1 async read
//    port; top adds output register for FWFT=0. Control, count, flags, errors in top.
// TESTING
//  1 Reset: drive rst_n=0 2 cycles mid-stream -> count=0, empty=1, full=0, r_valid=0, r_data=0.
//  2 Fill/drain D=16 W=8: write 0x00..0x0F -> full=1, count=16, almost_full from count 12;
//    read 16 -> data 0x00..0x0F in order, r_valid 1 cycle after each r_en, empty=1.
//  3 Full + w_en&r_en: at count=16 write 0xAA, read -> count stays 16, overflow=0, 0xAA read last.
//  4 Errors: w_en on full (no r_en) -> overflow=1, count 16, data unchanged; r_en on empty ->
//    underflow=1; clr_err -> both 0 next cycle; clr_err with new fault -> stays 1.
//  5 Non-power-of-two DEPTH=5: 3 wrap-around fill/drain cycles with pattern 0x10+i -> order kept,
//    full exactly at count 5, pointers wrap 4->0.
//  6 FWFT=1: write 0x5A into empty -> r_valid=1, r_data=0x5A next cycle without r_en; pop ->
//    empty=1, r_valid=0; back-to-back 0x01,0x02 -> 0x02 shown cycle after popping 0x01.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: width calculators,
// pointer wrap function and read-mode constants.
package fifo_pkg;

    // Read-side presentation modes
    localparam int unsigned FIFO_MODE_STD  = 0;  // registered read, data one cycle after r_en
    localparam int unsigned FIFO_MODE_FWFT = 1;  // head word always shown on r_data

    // Occupancy counter width: must hold 0..depth inclusive
    function automatic int unsigned fifo_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: indexes 0..depth-1, never narrower than one bit
    function automatic int unsigned fifo_pw(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer increment with explicit wrap so non-power-of-two depths work
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port. No reset; contents are only meaningful between the pointers.
module fifo_mem_2p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: one word per clock when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow errors and an
// optional first-word-fall-through read side.
//
// Handshake: a write is taken on a clock edge when w_en is high and the FIFO
// is not full, or when it is full but a read is taken on the same edge. A
// read is taken when r_en is high and the FIFO is not empty. In standard mode
// r_valid marks the cycle after a taken read, with r_data holding that word;
// in FWFT mode r_valid/r_data present the head word and r_en acknowledges it.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4,
    parameter int unsigned FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       w_data,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        r_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [fifo_cw(DEPTH)-1:0]   count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        clr_err
);

    localparam int unsigned CW = fifo_cw(DEPTH);
    localparam int unsigned PW = fifo_pw(DEPTH);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    // Reject configurations whose flags or counters would be meaningless
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL must be below DEPTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags are plain decodes of the registered occupancy
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO only lands if the head is leaving the same edge
    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    // Next-state for pointers, occupancy and sticky error bits
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first so a fresh error in the same cycle keeps the bit set
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en & full & ~rd_acc) begin
            overflow_d = 1'b1;
        end
        if (r_en & empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & rst_n),
        .waddr (wr_ptr_q),
        .wdata (w_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly from the storage array
        assign r_data  = mem_rdata;
        assign r_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
        logic                  r_valid_q, r_valid_d;

        // Capture the head word on a taken read; otherwise hold the last word
        always_comb begin
            r_data_d  = r_data_q;
            r_valid_d = rd_acc;
            if (rd_acc) begin
                r_data_d = mem_rdata;
            end
        end

        // Output register for the standard read path
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end

endmodule
